// File: rtl/vchess_pkg.sv
// Shared chess-engine definitions: square/board geometry, empty-square code, feeder FSM states
// and the per-position command record latched by the board feeder.
package vchess_pkg;

    localparam int PIECE_WIDTH = 4;
    localparam int NUM_SQUARES = 64;
    localparam int BOARD_WIDTH = PIECE_WIDTH * NUM_SQUARES;

    localparam logic [PIECE_WIDTH-1:0] EMPTY_POSN = '0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RESULT = 3'd3,
        CLEAR  = 3'd4
    } feeder_state_e;

    // Side-to-move, castling rights and en-passant column travel with the board.
    typedef struct packed {
        logic       white_to_move;
        logic [3:0] castle_mask;
        logic [3:0] en_passant_col;
    } pos_cmd_t;

endpackage

// File: rtl/eval_board_feeder_if.sv
// Bundle of every handshake/bus signal between the board feeder (master) and its
// environment: command source, square stream, evaluate/board_attack and result sink (slave).
interface eval_board_feeder_if
    import vchess_pkg::*;
#(
    parameter int EVAL_WIDTH = 24
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_white_to_move;
    logic [3:0]                    cmd_castle_mask;
    logic [3:0]                    cmd_en_passant_col;

    logic                          sq_valid;
    logic                          sq_ready;
    logic [PIECE_WIDTH-1:0]        sq_piece;
    logic                          sq_last;

    logic [BOARD_WIDTH-1:0]        board;
    logic                          board_valid;
    logic                          white_to_move;
    logic [3:0]                    castle_mask;
    logic [3:0]                    en_passant_col;
    logic                          clear_eval;
    logic                          clear_attack;

    logic signed [EVAL_WIDTH-1:0]  eval;
    logic                          eval_valid;

    logic                          res_valid;
    logic                          res_ready;
    logic signed [EVAL_WIDTH-1:0]  res_eval;
    logic                          res_error;

    modport master (
        input  cmd_valid, cmd_white_to_move, cmd_castle_mask, cmd_en_passant_col,
        input  sq_valid, sq_piece, sq_last,
        input  eval, eval_valid,
        input  res_ready,
        output cmd_ready, sq_ready,
        output board, board_valid, white_to_move, castle_mask, en_passant_col,
        output clear_eval, clear_attack,
        output res_valid, res_eval, res_error
    );

    modport slave (
        output cmd_valid, cmd_white_to_move, cmd_castle_mask, cmd_en_passant_col,
        output sq_valid, sq_piece, sq_last,
        output eval, eval_valid,
        output res_ready,
        input  cmd_ready, sq_ready,
        input  board, board_valid, white_to_move, castle_mask, en_passant_col,
        input  clear_eval, clear_attack,
        input  res_valid, res_eval, res_error
    );

endinterface

// File: rtl/eval_feeder_watchdog.sv
// SETTLE watchdog for the board feeder: counts enabled cycles from a clear and flags expiry
// during the TIMEOUT_CYCLES-th enabled cycle. Only used when EVAL_FEEDER_TIMEOUT_EN is defined.
module eval_feeder_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is combinational so the owner can still let a same-cycle eval_valid win.
    assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/eval_board_feeder.sv
// Initiator of the board_valid -> eval_valid protocol: assembles a board from a square stream,
// holds it for evaluate/board_attack, returns eval, then pulses the clears. Option: EVAL_FEEDER_TIMEOUT_EN.
module eval_board_feeder
    import vchess_pkg::*;
#(
    parameter int EVAL_WIDTH = 24
`ifdef EVAL_FEEDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    eval_board_feeder_if.master bus
);
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_LOAD   = LOAD;
    localparam logic [2:0] ST_SETTLE = SETTLE;
    localparam logic [2:0] ST_RESULT = RESULT;
    localparam logic [2:0] ST_CLEAR  = CLEAR;

    localparam logic [5:0] LAST_IDX = 6'(NUM_SQUARES - 1);

    logic [2:0]                   state_q, state_d;
    logic [5:0]                   idx_q, idx_d;
    pos_cmd_t                     cmd_q, cmd_d;
    logic signed [EVAL_WIDTH-1:0] res_eval_q, res_eval_d;
    logic                         res_error_q, res_error_d;

    // Handshake outputs are registered copies of the next state so they reset to 0.
    logic cmd_ready_q;
    logic sq_ready_q;
    logic board_valid_q;
    logic clear_q;
    logic res_valid_q;

    logic cmd_fire;
    logic sq_fire;
    logic res_fire;
    logic wd_expired;

    assign cmd_fire = cmd_ready_q && bus.cmd_valid;
    assign sq_fire  = sq_ready_q && bus.sq_valid;
    assign res_fire = res_valid_q && bus.res_ready;

`ifdef EVAL_FEEDER_TIMEOUT_EN
    eval_feeder_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (state_q != ST_SETTLE),
        .en_i      (state_q == ST_SETTLE),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        res_eval_d  = res_eval_q;
        res_error_d = res_error_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    cmd_d.white_to_move  = bus.cmd_white_to_move;
                    cmd_d.castle_mask    = bus.cmd_castle_mask;
                    cmd_d.en_passant_col = bus.cmd_en_passant_col;
                    idx_d       = '0;
                    res_eval_d  = '0;
                    res_error_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (sq_fire) begin
                    // The index never wraps: square 63 always ends the stream, good or bad.
                    if (bus.sq_last) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_SETTLE;
                        end else begin
                            res_error_d = 1'b1;
                            state_d     = ST_RESULT;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        res_error_d = 1'b1;
                        state_d     = ST_RESULT;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (bus.eval_valid) begin
                    res_eval_d = bus.eval;
                    state_d    = ST_RESULT;
                end else if (wd_expired) begin
                    res_eval_d  = '0;
                    res_error_d = 1'b1;
                    state_d     = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_fire) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cmd_q         <= '0;
            res_eval_q    <= '0;
            res_error_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            sq_ready_q    <= 1'b0;
            board_valid_q <= 1'b0;
            clear_q       <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cmd_q         <= cmd_d;
            res_eval_q    <= res_eval_d;
            res_error_q   <= res_error_d;
            cmd_ready_q   <= (state_d == ST_IDLE);
            sq_ready_q    <= (state_d == ST_LOAD);
            board_valid_q <= (state_d == ST_SETTLE);
            clear_q       <= (state_d == ST_CLEAR);
            res_valid_q   <= (state_d == ST_RESULT);
        end
    end

    // One register per square so the whole board is presented in parallel.
    generate
        for (genvar gi = 0; gi < NUM_SQUARES; gi++) begin : g_square
            logic                   we;
            logic [PIECE_WIDTH-1:0] piece_q;

            assign we = sq_fire && (idx_q == 6'(gi));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    piece_q <= EMPTY_POSN;
                end else if (cmd_fire) begin
                    piece_q <= EMPTY_POSN;
                end else if (we) begin
                    piece_q <= bus.sq_piece;
                end
            end

            assign bus.board[gi*PIECE_WIDTH +: PIECE_WIDTH] = piece_q;
        end
    endgenerate

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.sq_ready       = sq_ready_q;
    assign bus.board_valid    = board_valid_q;
    assign bus.white_to_move  = cmd_q.white_to_move;
    assign bus.castle_mask    = cmd_q.castle_mask;
    assign bus.en_passant_col = cmd_q.en_passant_col;
    assign bus.clear_eval     = clear_q;
    assign bus.clear_attack   = clear_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_eval       = res_eval_q;
    assign bus.res_error      = res_error_q;

endmodule
